// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, funct/ALU control codes and the funct->ctrl decode
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam logic [3:0] FUNCT_ADD = 4'h0;
  localparam logic [3:0] FUNCT_SUB = 4'h2;
  localparam logic [3:0] FUNCT_SLT = 4'hA;
  localparam logic [3:0] CTRL_NOP = 4'd0;
  localparam logic [3:0] CTRL_ADD = 4'd2;
  localparam logic [3:0] CTRL_SUB = 4'd6;
  localparam logic [3:0] CTRL_SLT = 4'd7;
  function automatic logic [3:0] funct_to_ctrl(input logic [3:0] funct);
    return funct == FUNCT_ADD ? CTRL_ADD :
           funct == FUNCT_SUB ? CTRL_SUB :
           funct == FUNCT_SLT ? CTRL_SLT : CTRL_NOP;
  endfunction
endpackage

// File: rtl/alu_fwd_mux.sv
// alu_fwd_mux: per-operand priority select of r0, EX result, WB data or register-file read
module alu_fwd_mux import alu_pkg::*; (
  input  logic [REG_AW-1:0] src,
  input  logic              ex_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);
  assign data = src == '0                  ? '0      :
                ex_en && ex_rd == src      ? ex_data :
                wb_en && wb_rd == src      ? wb_data : rf_data;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback pipeline around an external combinational ALU
module alu_issue import alu_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_funct,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic [DATA_W-1:0] source1,
  output logic [DATA_W-1:0] source2,
  output logic [3:0]        ALU_CTRL,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_illegal
);
  logic              ex_valid;
  logic              ex_illegal;
  logic [REG_AW-1:0] ex_rd;
  logic              wb_free;
  logic              ex_adv;
  logic              in_fire;
  logic [3:0]        ctrl;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  assign wb_free  = !wb_valid || wb_ready;
  assign ex_adv   = ex_valid && wb_free;
  assign in_ready = !ex_valid || wb_free;
  assign in_fire  = in_valid && in_ready;
  assign ctrl     = funct_to_ctrl(in_funct);

  alu_fwd_mux u_fwd_rs (
    .src(in_rs), .ex_en(ex_valid && !ex_illegal), .ex_rd(ex_rd), .ex_data(alu_result),
    .wb_en(wb_valid && !wb_illegal), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_data(in_rs_val), .data(rs_fwd)
  );

  alu_fwd_mux u_fwd_rt (
    .src(in_rt), .ex_en(ex_valid && !ex_illegal), .ex_rd(ex_rd), .ex_data(alu_result),
    .wb_en(wb_valid && !wb_illegal), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_data(in_rt_val), .data(rt_fwd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_rd      <= '0;
      source1    <= '0;
      source2    <= '0;
      ALU_CTRL   <= CTRL_NOP;
    end else if (in_fire) begin
      ex_valid   <= 1'b1;
      ex_illegal <= ctrl == CTRL_NOP;
      ex_rd      <= in_rd;
      source1    <= rs_fwd;
      source2    <= rt_fwd;
      ALU_CTRL   <= ctrl;
    end else if (ex_adv) begin
      ex_valid   <= 1'b0;
    end
  end

  // illegal entries write back zero regardless of what the ALU does with CTRL_NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_illegal <= 1'b0;
    end else if (ex_adv) begin
      wb_valid   <= 1'b1;
      wb_rd      <= ex_rd;
      wb_data    <= ex_illegal ? '0 : alu_result;
      wb_illegal <= ex_illegal;
    end else if (wb_ready) begin
      wb_valid   <= 1'b0;
    end
  end
endmodule
